// File: rtl/mem_wb_reg.sv
// ============================================================================
// mem_wb_reg : MEM/WB pipeline register with bubble-on-freeze behaviour and
//              saturating retired-instruction / stall-cycle counters.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef REGISTER_LEN
`define REGISTER_LEN 32
`endif

module mem_wb_reg (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze_MEM,
  input  logic                     valid_in,
  input  logic                     wb_en_in,
  input  logic                     mem_read_in,
  input  logic [3:0]               dest_in,
  input  logic [`ADDRESS_LEN-1:0]  pc_in,
  input  logic [`REGISTER_LEN-1:0] alu_res_in,
  input  logic [`REGISTER_LEN-1:0] data_mem_in,
  input  logic                     clear_counters,
  output logic                     wb_en_out,
  output logic [3:0]               dest_out,
  output logic [`REGISTER_LEN-1:0] wb_value_out,
  output logic [`ADDRESS_LEN-1:0]  pc_out,
  output logic                     valid_out,
  output logic [31:0]              retired_count,
  output logic [31:0]              stall_count
);

  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  logic                     valid_q,    valid_d;
  logic                     wb_en_q,    wb_en_d;
  logic [3:0]               dest_q,     dest_d;
  logic [`ADDRESS_LEN-1:0]  pc_q,       pc_d;
  logic [`REGISTER_LEN-1:0] wb_value_q, wb_value_d;
  logic [31:0]              retired_count_q, retired_count_d;
  logic [31:0]              stall_count_q,   stall_count_d;

  always_comb begin
    valid_d         = 1'b0;
    wb_en_d         = 1'b0;
    dest_d          = dest_q;
    pc_d            = pc_q;
    wb_value_d      = wb_value_q;
    retired_count_d = retired_count_q;
    stall_count_d   = stall_count_q;

    // A frozen stage emits a bubble; the held instruction is captured once
    // the freeze lifts, so it writes back exactly once.
    if (!freeze_MEM) begin
      valid_d    = valid_in;
      wb_en_d    = wb_en_in & valid_in;
      dest_d     = dest_in;
      pc_d       = pc_in;
      wb_value_d = mem_read_in ? data_mem_in : alu_res_in;
    end

    if (clear_counters) begin
      retired_count_d = '0;
      stall_count_d   = '0;
    end else begin
      if (valid_in && !freeze_MEM && (retired_count_q != C_CNT_MAX))
        retired_count_d = retired_count_q + 32'd1;
      if (freeze_MEM && (stall_count_q != C_CNT_MAX))
        stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q         <= 1'b0;
      wb_en_q         <= 1'b0;
      dest_q          <= '0;
      pc_q            <= '0;
      wb_value_q      <= '0;
      retired_count_q <= '0;
      stall_count_q   <= '0;
    end else begin
      valid_q         <= valid_d;
      wb_en_q         <= wb_en_d;
      dest_q          <= dest_d;
      pc_q            <= pc_d;
      wb_value_q      <= wb_value_d;
      retired_count_q <= retired_count_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign valid_out     = valid_q;
  assign wb_en_out     = wb_en_q;
  assign dest_out      = dest_q;
  assign pc_out        = pc_q;
  assign wb_value_out  = wb_value_q;
  assign retired_count = retired_count_q;
  assign stall_count   = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_reg.sv
// ============================================================================
// tb_mem_wb_reg : table-driven, scoreboarded bench for mem_wb_reg.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef REGISTER_LEN
`define REGISTER_LEN 32
`endif

module tb_mem_wb_reg;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     freeze_MEM, valid_in, wb_en_in, mem_read_in, clear_counters;
  logic [3:0]               dest_in;
  logic [`ADDRESS_LEN-1:0]  pc_in;
  logic [`REGISTER_LEN-1:0] alu_res_in, data_mem_in;
  logic                     wb_en_out, valid_out;
  logic [3:0]               dest_out;
  logic [`REGISTER_LEN-1:0] wb_value_out;
  logic [`ADDRESS_LEN-1:0]  pc_out;
  logic [31:0]              retired_count, stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  mem_wb_reg dut (
    .clk            (clk),
    .rst            (rst),
    .freeze_MEM     (freeze_MEM),
    .valid_in       (valid_in),
    .wb_en_in       (wb_en_in),
    .mem_read_in    (mem_read_in),
    .dest_in        (dest_in),
    .pc_in          (pc_in),
    .alu_res_in     (alu_res_in),
    .data_mem_in    (data_mem_in),
    .clear_counters (clear_counters),
    .wb_en_out      (wb_en_out),
    .dest_out       (dest_out),
    .wb_value_out   (wb_value_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .retired_count  (retired_count),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                     fr, v, we, mr, clr;
    logic [3:0]               d;
    logic [`ADDRESS_LEN-1:0]  pc;
    logic [`REGISTER_LEN-1:0] alu, dm;
    logic                     e_we, e_v;
    logic [3:0]               e_d;
    logic [`ADDRESS_LEN-1:0]  e_pc;
    logic [`REGISTER_LEN-1:0] e_val;
    logic [31:0]              e_ret, e_st;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[11];

  function automatic vec_t mk(
    input logic fr, input logic v, input logic we, input logic mr, input logic clr,
    input logic [3:0] d, input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dm,
    input logic e_we, input logic e_v, input logic [3:0] e_d, input logic [31:0] e_pc,
    input logic [31:0] e_val, input logic [31:0] e_ret, input logic [31:0] e_st);
    vec_t r;
    r.fr = fr; r.v = v; r.we = we; r.mr = mr; r.clr = clr;
    r.d = d; r.pc = pc; r.alu = alu; r.dm = dm;
    r.e_we = e_we; r.e_v = e_v; r.e_d = e_d; r.e_pc = e_pc;
    r.e_val = e_val; r.e_ret = e_ret; r.e_st = e_st;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, ".wb_en_out"},     64'(wb_en_out),     64'(e.e_we));
    check({tag, ".valid_out"},     64'(valid_out),     64'(e.e_v));
    check({tag, ".dest_out"},      64'(dest_out),      64'(e.e_d));
    check({tag, ".pc_out"},        64'(pc_out),        64'(e.e_pc));
    check({tag, ".wb_value_out"},  64'(wb_value_out),  64'(e.e_val));
    check({tag, ".retired_count"}, 64'(retired_count), 64'(e.e_ret));
    check({tag, ".stall_count"},   64'(stall_count),   64'(e.e_st));
  endtask

  // Drive on the falling edge, push the expectation, compare one after the rising edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    freeze_MEM = v.fr; valid_in = v.v; wb_en_in = v.we; mem_read_in = v.mr;
    clear_counters = v.clr; dest_in = v.d; pc_in = v.pc;
    alu_res_in = v.alu; data_mem_in = v.dm;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_all(tag, e);
  endtask

  vec_t zero_v;

  initial begin
    rst = 1'b0;
    freeze_MEM = 0; valid_in = 0; wb_en_in = 0; mem_read_in = 0; clear_counters = 0;
    dest_in = 0; pc_in = 0; alu_res_in = 0; data_mem_in = 0;
    zero_v = mk(0,0,0,0,0, 4'h0, 0, 0, 0, 0,0, 4'h0, 0, 0, 0, 0);

    //          fr v we mr clr  d     pc            alu           dm            we v  d     pc            val           ret           st
    tbl[0]  = mk(0,1,1,0,0, 4'h3, 32'h100,      32'h10,       32'h0,        1,1, 4'h3, 32'h100,      32'h10,       32'd1,        32'd0);
    tbl[1]  = mk(1,1,1,1,0, 4'h5, 32'h104,      32'h2000,     32'hDEADBEEF, 0,0, 4'h3, 32'h100,      32'h10,       32'd1,        32'd1);
    tbl[2]  = mk(1,1,1,1,0, 4'h5, 32'h104,      32'h2000,     32'hDEADBEEF, 0,0, 4'h3, 32'h100,      32'h10,       32'd1,        32'd2);
    tbl[3]  = mk(1,1,1,1,0, 4'h5, 32'h104,      32'h2000,     32'hDEADBEEF, 0,0, 4'h3, 32'h100,      32'h10,       32'd1,        32'd3);
    tbl[4]  = mk(0,1,1,1,0, 4'h5, 32'h104,      32'h2000,     32'hDEADBEEF, 1,1, 4'h5, 32'h104,      32'hDEADBEEF, 32'd2,        32'd3);
    tbl[5]  = mk(0,0,1,0,0, 4'h7, 32'h108,      32'h55,       32'h0,        0,0, 4'h7, 32'h108,      32'h55,       32'd2,        32'd3);
    tbl[6]  = mk(0,1,0,1,0, 4'h9, 32'h10C,      32'h1,        32'hCAFEF00D, 0,1, 4'h9, 32'h10C,      32'hCAFEF00D, 32'd3,        32'd3);
    tbl[7]  = mk(0,1,1,0,1, 4'hA, 32'h110,      32'h77,       32'h0,        1,1, 4'hA, 32'h110,      32'h77,       32'd0,        32'd0);
    tbl[8]  = mk(1,1,1,0,1, 4'hB, 32'h114,      32'h99,       32'h0,        0,0, 4'hA, 32'h110,      32'h77,       32'd0,        32'd0);
    tbl[9]  = mk(1,0,1,0,0, 4'hC, 32'h118,      32'h88,       32'h0,        0,0, 4'hA, 32'h110,      32'h77,       32'd0,        32'd1);
    tbl[10] = mk(0,1,1,0,0, 4'hF, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h12345678, 1,1, 4'hF, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd1,        32'd1);

    // Reset state while rst is held low across an edge.
    @(posedge clk);
    #1;
    check_all("reset", zero_v);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Saturation: preload both counters at their maximum.
    force dut.retired_count_q = 32'hFFFF_FFFF;
    force dut.stall_count_q   = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count_q;
    release dut.stall_count_q;
    step("sat_retire", mk(0,1,1,0,0, 4'h2, 32'h200, 32'h5, 32'h0, 1,1, 4'h2, 32'h200, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF));
    step("sat_stall",  mk(1,1,1,0,0, 4'h2, 32'h200, 32'h5, 32'h0, 0,0, 4'h2, 32'h200, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF));
    step("sat_clear",  mk(1,1,1,0,1, 4'h2, 32'h200, 32'h5, 32'h0, 0,0, 4'h2, 32'h200, 32'h5, 32'd0,        32'd0));

    // Asynchronous reset in the middle of a write-back cycle.
    step("pre_rst", mk(0,1,1,0,0, 4'h6, 32'h300, 32'h66, 32'h0, 1,1, 4'h6, 32'h300, 32'h66, 32'd1, 32'd0));
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", zero_v);
    freeze_MEM = 1; valid_in = 1; wb_en_in = 1; dest_in = 4'h8; pc_in = 32'h400; alu_res_in = 32'h88;
    @(negedge clk);
    rst = 1'b1;
    step("rst_frozen", mk(1,1,1,0,0, 4'h8, 32'h400, 32'h88, 32'h0, 0,0, 4'h0, 32'h0, 32'h0, 32'd0, 32'd2));
    step("rst_resume", mk(0,1,1,0,0, 4'h8, 32'h400, 32'h88, 32'h0, 1,1, 4'h8, 32'h400, 32'h88, 32'd1, 32'd2));

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
